reactor_temp_sensor: RTL and testbench

Sensor front end that produces the 1-bit overheat request `S` consumed by the reactor safety state machine. Samples a digitized core-temperature code, applies hysteresis thresholds and consecutive-sample debouncing, and flags sensor faults (stuck-high code, optional missing-sample watchdog). A fault forces `S` high, which is the fail-safe direction. Sits between the temperature ADC interface and the reactor control FSM's `S` input.

---
 rtl/reactor_temp_sensor.sv | 178 +++++++++++++++++
 tb/tb_reactor_temp_sensor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reactor_temp_sensor.sv
// reactor_temp_sensor: overheat request front end for the reactor safety FSM.
// Classifies each accepted temperature code, applies hysteresis thresholds and
// consecutive-sample debouncing, and forces S high on a sensor fault.
// Optional build macro: REACTOR_SENSOR_WATCHDOG_EN adds a missing-sample
// watchdog that enters FAULT after TIMEOUT clocks without a valid sample.
module reactor_temp_sensor #(
  parameter int WIDTH    = 10,
  parameter int T_HIGH   = 800,
  parameter int T_LOW    = 750,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] TEMP,
  input  logic             TEMP_VALID,
  output logic             S,
  output logic             SENSOR_FAULT,
  output logic [WIDTH-1:0] TEMP_LAST
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]    DEB_C    = CW'(DEBOUNCE);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] T_HIGH_C = WIDTH'(T_HIGH);
  localparam logic [WIDTH-1:0] T_LOW_C  = WIDTH'(T_LOW);

  typedef enum logic [2:0] {
    ST_NORMAL  = 3'd0,
    ST_RISING  = 3'd1,
    ST_HOT     = 3'd2,
    ST_FALLING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             s_q, s_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             is_fault, is_hot, is_cool;
  logic             wd_expire;

  // Sample classification; an all-ones code is never treated as hot.
  always_comb begin
    is_fault = (TEMP == ALL_ONES);
    is_hot   = !is_fault && (TEMP >= T_HIGH_C);
    is_cool  = (TEMP < T_LOW_C);
    cnt_inc  = (cnt_q == DEB_C) ? cnt_q : cnt_q + 1'b1;
  end

`ifdef REACTOR_SENSOR_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_C = WW'(TIMEOUT);
  logic [WW-1:0] wd_q, wd_d;

  // Watchdog next value: count idle clocks, saturate at TIMEOUT, clear on a sample.
  always_comb begin
    wd_d      = wd_q;
    wd_expire = 1'b0;
    if (TEMP_VALID) begin
      wd_d = '0;
    end else begin
      if (wd_q != TO_C) wd_d = wd_q + 1'b1;
      wd_expire = (wd_d == TO_C);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  // TIMEOUT has no function without the watchdog.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
`endif

  // Next-state and registered-output logic for the debounce/hysteresis FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (TEMP_VALID) begin
      last_d = TEMP;
      if (is_fault) begin
        state_d = ST_FAULT;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_NORMAL: if (is_hot) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_HOT;
              cnt_d   = '0;
            end else begin
              state_d = ST_RISING;
              cnt_d   = CW'(1);
            end
          end
          ST_RISING: if (is_hot) begin
            if (cnt_inc == DEB_C) begin
              state_d = ST_HOT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end
          ST_HOT: if (is_cool) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_NORMAL;
              cnt_d   = '0;
            end else begin
              state_d = ST_FALLING;
              cnt_d   = CW'(1);
            end
          end
          ST_FALLING: if (is_cool) begin
            if (cnt_inc == DEB_C) begin
              state_d = ST_NORMAL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_HOT;
            cnt_d   = '0;
          end
          ST_FAULT: begin
            // Leave a fault only into HOT, the conservative side.
            if (cnt_inc == DEB_C) begin
              state_d = ST_HOT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end
        endcase
      end
    end else if (wd_expire) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end
    s_d     = (state_d == ST_HOT) || (state_d == ST_FALLING) || (state_d == ST_FAULT);
    fault_d = (state_d == ST_FAULT);
  end

  // State, counter and output registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      fault_q <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      fault_q <= fault_d;
      last_q  <= last_d;
    end
  end

  assign S            = s_q;
  assign SENSOR_FAULT = fault_q;
  assign TEMP_LAST    = last_q;

endmodule

// File: tb/tb_reactor_temp_sensor.sv
// Testbench for reactor_temp_sensor: directed vectors, a flag-and-run-length
// reference model checked every cycle, plus hand-computed literal checks.
module tb_reactor_temp_sensor;

  localparam int WIDTH = 10;
  localparam int THI   = 800;
  localparam int TLO   = 750;
  localparam int DEB   = 4;
  localparam int TOUT  = 8;

  logic             CLOCK;
  logic             RESET_N;
  logic [WIDTH-1:0] TEMP;
  logic             TEMP_VALID;
  logic             S;
  logic             SENSOR_FAULT;
  logic [WIDTH-1:0] TEMP_LAST;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  started = 0;

  reactor_temp_sensor #(
    .WIDTH(WIDTH), .T_HIGH(THI), .T_LOW(TLO), .DEBOUNCE(DEB), .TIMEOUT(TOUT)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .TEMP(TEMP), .TEMP_VALID(TEMP_VALID),
    .S(S), .SENSOR_FAULT(SENSOR_FAULT), .TEMP_LAST(TEMP_LAST)
  );

  initial begin
    CLOCK = 0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Reference model: overheat flag, fault flag, and length of the current
  // run of samples that argue for leaving the present condition.
  bit m_s, m_flt;
  int m_run, m_wd;
  int m_last;

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_s = 0; m_flt = 0; m_run = 0; m_wd = 0; m_last = 0;
    end else if (TEMP_VALID) begin
      m_last = TEMP;
      m_wd   = 0;
      if (TEMP == 10'd1023) begin
        m_flt = 1; m_s = 1; m_run = 0;
      end else if (m_flt) begin
        m_run++;
        if (m_run >= DEB) begin m_flt = 0; m_s = 1; m_run = 0; end
      end else begin
        if (m_s ? (int'(TEMP) < TLO) : (int'(TEMP) >= THI)) m_run++;
        else m_run = 0;
        if (m_run >= DEB) begin m_s = !m_s; m_run = 0; end
      end
    end else begin
`ifdef REACTOR_SENSOR_WATCHDOG_EN
      if (m_wd < TOUT) m_wd++;
      if (m_wd == TOUT) begin m_flt = 1; m_s = 1; m_run = 0; end
`endif
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK) begin
    if (started && RESET_N) begin
      chk("cyc_S", int'(S), int'(m_s));
      chk("cyc_FAULT", int'(SENSOR_FAULT), int'(m_flt));
      chk("cyc_LAST", int'(TEMP_LAST), m_last);
    end
  end

  // One clock: drive at the falling edge, return just after the rising edge.
  task automatic step(input bit v, input int t);
    @(negedge CLOCK);
    TEMP_VALID = v;
    TEMP       = WIDTH'(t);
    @(posedge CLOCK);
    #1;
    $display("cycle t=%0t valid=%0d temp=%0d -> S=%0d SF=%0d LAST=%0d",
             $time, v, t, S, SENSOR_FAULT, TEMP_LAST);
  endtask

  task automatic samples(input int t, input int n);
    for (int i = 0; i < n; i++) step(1, t);
  endtask

  task automatic chk3(input string name, input int s, input int f, input int last);
    chk({name, "_S"}, int'(S), s);
    chk({name, "_FAULT"}, int'(SENSOR_FAULT), f);
    chk({name, "_LAST"}, int'(TEMP_LAST), last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 0; TEMP = '0; TEMP_VALID = 0;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1;
    started = 1;
    #1;
    chk3("reset", 0, 0, 0);

    // Rise after four consecutive hot samples.
    samples(820, 3);
    chk3("rise3", 0, 0, 820);
    step(1, 820);
    chk3("rise4", 1, 0, 820);

    // Falling run broken by a mid sample, then completed.
    samples(700, 2);
    step(1, 760);
    chk3("fall_mid", 1, 0, 760);
    samples(700, 3);
    chk3("fall3", 1, 0, 700);
    step(1, 700);
    chk3("fall4", 0, 0, 700);

    // Rising run broken by a mid sample.
    samples(820, 2);
    step(1, 780);
    chk3("rise_mid", 0, 0, 780);
    step(1, 820);
    chk3("rise_after_mid", 0, 0, 820);
    step(1, 500);

    // Idle cycles inside a run do not break it.
    for (int i = 0; i < 4; i++) begin
      step(1, 820);
      if (i < 3) repeat (3) step(0, 0);
    end
    chk3("idle_run", 1, 0, 820);

    // Threshold boundaries: 750 is mid, 749 cool, 799 mid, 800 hot.
    samples(750, 4);
    chk3("b750", 1, 0, 750);
    samples(749, 4);
    chk3("b749", 0, 0, 749);
    samples(799, 4);
    chk3("b799", 0, 0, 799);
    samples(800, 4);
    chk3("b800", 1, 0, 800);
    samples(700, 4);
    chk3("back_normal", 0, 0, 700);

    // Fault code from NORMAL, conservative exit into HOT, then cool down.
    step(1, 1023);
    chk3("fault_in", 1, 1, 1023);
    samples(500, 3);
    chk3("fault_hold", 1, 1, 500);
    step(1, 500);
    chk3("fault_exit", 1, 0, 500);
    samples(500, 4);
    chk3("fault_cool", 0, 0, 500);

    // Fault in the middle of a rising run; repeated fault codes hold FAULT.
    samples(820, 2);
    step(1, 1023);
    step(1, 820);
    step(1, 1023);
    chk3("fault_rising", 1, 1, 1023);
    samples(820, 4);
    chk3("fault_exit2", 1, 0, 820);
    samples(700, 4);
    chk3("cool2", 0, 0, 700);

    // Missing samples.
    repeat (7) step(0, 0);
    chk3("idle7", 0, 0, 700);
    step(0, 0);
`ifdef REACTOR_SENSOR_WATCHDOG_EN
    chk3("idle8", 1, 1, 700);
`else
    chk3("idle8", 0, 0, 700);
`endif
    repeat (20) step(0, 0);
`ifdef REACTOR_SENSOR_WATCHDOG_EN
    chk3("idle28", 1, 1, 700);
`else
    chk3("idle28", 0, 0, 700);
`endif
    samples(500, 8);
    chk3("after_idle", 0, 0, 500);

    // Asynchronous reset while in FAULT.
    step(1, 1023);
    chk3("pre_reset", 1, 1, 1023);
    @(negedge CLOCK);
    TEMP_VALID = 0;
    #2 RESET_N = 0;
    #1;
    chk3("async_reset", 0, 0, 0);
    @(negedge CLOCK);
    RESET_N = 1;
    step(0, 0);
    chk3("post_reset", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
